conv_result_collector: RTL and testbench

- Sits directly downstream of the 81-input, 6-stage pipelined adder tree in the convolution accelerator.
- Tracks beat validity alongside the tree's untagged pipeline and accumulates tree sums across input channels.
- On the last channel of each output pixel, scales the total, saturates it and queues the result for the write-back side on a valid/ready interface.
- Issues flow-control credit back to the launcher that feeds the tree.

---
 rtl/conv_result_collector.sv | 143 ++++++++++++++
 tb/tb_conv_result_collector.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_collector.sv
// Result collector behind the pipelined adder tree: tags beats through the tree latency,
// accumulates channel sums, scales and saturates each pixel, and queues results with credit return.
module conv_result_collector #(
   parameter int W        = 64,
   parameter int TREE_LAT = 6,
   parameter int OUT_W    = 32,
   parameter int DEPTH    = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clear_i,
   input  logic                launch_valid_i,
   input  logic                launch_last_i,
   output logic                launch_ready_o,
   input  logic signed [W-1:0] sum_i,
   input  logic [5:0]          shift_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [OUT_W-1:0]    out_data_o,
   output logic                drop_o
);

   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int OUTST_W = $clog2(DEPTH + TREE_LAT + 1);

   localparam logic signed [W-1:0] SAT_MAX = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [W-1:0] SAT_MIN = {{(W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef struct packed {
      logic valid;
      logic last;
   } tag_t;

   tag_t                tag_q [TREE_LAT];
   logic signed [W-1:0] acc_q;
   logic [OUT_W-1:0]    mem_q [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q;
   logic [PTR_W-1:0]    rd_ptr_q;
   logic [CNT_W-1:0]    count_q;

   tag_t                aligned;
   logic                accept;
   logic                push;
   logic                pop;
   logic signed [W-1:0] total;
   logic signed [W-1:0] shifted;
   logic [OUT_W-1:0]    sat_value;
   logic [OUTST_W-1:0]  outstanding;

   // Every pixel already launched but not yet popped holds one credit, so a push
   // can never meet a full FIFO without a simultaneous pop.
   // NOTE: combinational blocks use blocking '=' and assign every output before any
   // conditional use, so no latch is inferred; clocked state uses '<=' only.
   always_comb begin
      outstanding = OUTST_W'(count_q);
      for (int i = 0; i < TREE_LAT; i++) begin
         outstanding = outstanding + OUTST_W'(tag_q[i].valid & tag_q[i].last);
      end
   end

   assign launch_ready_o = (outstanding < OUTST_W'(DEPTH));
   assign accept         = launch_valid_i && launch_ready_o;
   assign aligned        = tag_q[TREE_LAT-1];
   assign push           = aligned.valid && aligned.last;
   assign pop            = out_valid_o && out_ready_i;

   always_comb begin
      total   = acc_q + sum_i;
      shifted = total >>> shift_i;
      if (shifted > SAT_MAX) begin
         sat_value = SAT_MAX[OUT_W-1:0];
      end else if (shifted < SAT_MIN) begin
         sat_value = SAT_MIN[OUT_W-1:0];
      end else begin
         sat_value = shifted[OUT_W-1:0];
      end
   end

   // Tag delay line mirrors the untagged tree pipeline; sums with an invalid tag are ignored.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < TREE_LAT; i++) begin
            tag_q[i] <= '0;
         end
         acc_q  <= '0;
         drop_o <= 1'b0;
      end else if (clear_i) begin
         for (int i = 0; i < TREE_LAT; i++) begin
            tag_q[i] <= '0;
         end
         acc_q  <= '0;
         drop_o <= 1'b0;
      end else begin
         tag_q[0] <= tag_t'{valid: accept, last: launch_last_i};
         for (int i = 1; i < TREE_LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
         if (aligned.valid) begin
            acc_q <= aligned.last ? '0 : total;
         end
         if (launch_valid_i && !launch_ready_o) begin
            drop_o <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: the storage array is deliberately not reset; an entry is only observable
   // after it has been written, and out_data_o is forced to zero while empty.
   always_ff @(posedge clk_i) begin
      if (push && !clear_i) begin
         mem_q[wr_ptr_q] <= sat_value;
      end
   end

   assign out_valid_o = (count_q != '0);
   assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_conv_result_collector.sv
// Bench for conv_result_collector: emulates the adder tree delay and predicts results,
// credit, and drop behaviour from a pixel-level queue model.
module tb_conv_result_collector;

   localparam int W        = 64;
   localparam int TREE_LAT = 6;
   localparam int OUT_W    = 32;
   localparam int DEPTH    = 4;

   logic                clk_i = 1'b0;
   logic                rst_ni;
   logic                clear_i;
   logic                launch_valid_i;
   logic                launch_last_i;
   logic                launch_ready_o;
   logic signed [W-1:0] sum_i;
   logic [5:0]          shift_i;
   logic                out_valid_o;
   logic                out_ready_i;
   logic [OUT_W-1:0]    out_data_o;
   logic                drop_o;

   logic signed [W-1:0] launch_sum;
   logic signed [W-1:0] tree_pipe [TREE_LAT];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [OUT_W-1:0] value;
      int               visible;
   } exp_t;

   exp_t             exp_q [$];
   logic [OUT_W-1:0] got_q [$];
   longint           acc_m;
   bit               drop_m;

   conv_result_collector #(
      .W(W), .TREE_LAT(TREE_LAT), .OUT_W(OUT_W), .DEPTH(DEPTH)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .clear_i        (clear_i),
      .launch_valid_i (launch_valid_i),
      .launch_last_i  (launch_last_i),
      .launch_ready_o (launch_ready_o),
      .sum_i          (sum_i),
      .shift_i        (shift_i),
      .out_valid_o    (out_valid_o),
      .out_ready_i    (out_ready_i),
      .out_data_o     (out_data_o),
      .drop_o         (drop_o)
   );

   always #5 clk_i = ~clk_i;

   // The tree computes every presented operand set, valid or not, TREE_LAT cycles later.
   always @(posedge clk_i) begin
      tree_pipe[0] <= launch_sum;
      for (int i = 1; i < TREE_LAT; i++) tree_pipe[i] <= tree_pipe[i-1];
   end
   assign sum_i = tree_pipe[TREE_LAT-1];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
      $fatal(1);
   end

   function automatic logic [OUT_W-1:0] finalise(input longint total, input int sh);
      longint s;
      s = total >>> sh;
      if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
      if (s < -64'sd2147483648) return 32'h8000_0000;
      return s[31:0];
   endfunction

   task automatic reset_model();
      exp_q.delete();
      acc_m  = 0;
      drop_m = 1'b0;
   endtask

   // One clock cycle: compare DUT outputs with the model, then advance the model.
   task automatic tick();
      bit               m_ready;
      bit               m_valid;
      logic [OUT_W-1:0] m_data;
      m_ready = (exp_q.size() < DEPTH);
      m_valid = (exp_q.size() != 0) && (exp_q[0].visible <= cyc);
      m_data  = m_valid ? exp_q[0].value : '0;

      checks++;
      if (launch_ready_o !== m_ready) begin
         failures++;
         $display("FAIL launch_ready cyc=%0d got=%0b exp=%0b", cyc, launch_ready_o, m_ready);
      end
      checks++;
      if (out_valid_o !== m_valid) begin
         failures++;
         $display("FAIL out_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid_o, m_valid);
      end
      if (m_valid) begin
         checks++;
         if (out_data_o !== m_data) begin
            failures++;
            $display("FAIL out_data cyc=%0d got=%08h exp=%08h", cyc, out_data_o, m_data);
         end
      end
      checks++;
      if (drop_o !== drop_m) begin
         failures++;
         $display("FAIL drop cyc=%0d got=%0b exp=%0b", cyc, drop_o, drop_m);
      end

      if (out_valid_o === 1'b1 && out_ready_i === 1'b1) got_q.push_back(out_data_o);

      if (clear_i) begin
         reset_model();
      end else begin
         if (m_valid && out_ready_i) void'(exp_q.pop_front());
         if (launch_valid_i && !m_ready) drop_m = 1'b1;
         if (launch_valid_i && m_ready) begin
            acc_m = acc_m + launch_sum;
            if (launch_last_i) begin
               exp_q.push_back('{value: finalise(acc_m, int'(shift_i)), visible: cyc + TREE_LAT + 1});
               acc_m = 0;
            end
         end
      end
      cyc++;
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic beat(input bit v, input bit l, input longint s);
      launch_valid_i = v;
      launch_last_i  = l;
      launch_sum     = v ? s : {$urandom, $urandom};
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 0);
   endtask

   task automatic send_honour(input bit l, input longint s);
      int n;
      n = 0;
      while (launch_ready_o !== 1'b1 && n < 40) begin
         idle(1);
         n++;
      end
      if (n >= 40) begin
         checks++;
         failures++;
         $display("FAIL credit_timeout cyc=%0d got=%0b exp=1", cyc, launch_ready_o);
      end
      beat(1'b1, l, s);
   endtask

   task automatic expect_got(input string name, input logic [OUT_W-1:0] exp_vals [$]);
      checks++;
      if (got_q.size() !== exp_vals.size()) begin
         failures++;
         $display("FAIL %s_count got=%0d exp=%0d", name, got_q.size(), exp_vals.size());
      end else begin
         for (int i = 0; i < exp_vals.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_vals[i]) begin
               failures++;
               $display("FAIL %s_value[%0d] got=%08h exp=%08h", name, i, got_q[i], exp_vals[i]);
            end
         end
      end
   endtask

   task automatic test_reset();
      checks++;
      if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid_o); end
      checks++;
      if (out_data_o !== '0) begin failures++; $display("FAIL reset_out_data got=%08h exp=0", out_data_o); end
      checks++;
      if (drop_o !== 1'b0) begin failures++; $display("FAIL reset_drop got=%0b exp=0", drop_o); end
      checks++;
      if (launch_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", launch_ready_o); end
   endtask

   task automatic test_single_pixel();
      int t;
      int n;
      shift_i     = 6'd0;
      out_ready_i = 1'b0;
      t = cyc;
      beat(1'b1, 1'b1, 100);
      n = 0;
      while (out_valid_o !== 1'b1 && n < 20) begin
         idle(1);
         n++;
      end
      checks++;
      if (cyc - t !== TREE_LAT + 1) begin
         failures++;
         $display("FAIL single_latency got=%0d exp=%0d", cyc - t, TREE_LAT + 1);
      end
      checks++;
      if (out_data_o !== 32'd100) begin
         failures++;
         $display("FAIL single_data got=%08h exp=%08h", out_data_o, 32'd100);
      end
      out_ready_i = 1'b1;
      idle(1);
      checks++;
      if (out_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL single_pop got=%0b exp=0", out_valid_o);
      end
      idle(2);
   endtask

   task automatic test_multi_channel();
      got_q.delete();
      shift_i     = 6'd1;
      out_ready_i = 1'b1;
      beat(1'b1, 1'b0, 10);
      beat(1'b1, 1'b0, -3);
      beat(1'b1, 1'b1, 5);
      idle(12);
      beat(1'b1, 1'b1, -7);
      idle(12);
      expect_got("multi", '{32'd6, 32'hFFFF_FFFC});
   endtask

   task automatic test_saturation();
      longint big;
      big = longint'(1) << 40;
      got_q.delete();
      shift_i     = 6'd0;
      out_ready_i = 1'b1;
      beat(1'b1, 1'b1, big);
      beat(1'b1, 1'b1, -big);
      idle(12);
      shift_i = 6'd10;
      beat(1'b1, 1'b1, big);
      idle(12);
      expect_got("sat", '{32'h7FFF_FFFF, 32'h8000_0000, 32'h4000_0000});
   endtask

   task automatic test_backpressure();
      got_q.delete();
      shift_i     = 6'd0;
      out_ready_i = 1'b0;
      for (int i = 1; i <= 4; i++) beat(1'b1, 1'b1, longint'(i));
      checks++;
      if (launch_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL bp_credit_low got=%0b exp=0", launch_ready_o);
      end
      idle(10);
      checks++;
      if (drop_o !== 1'b0) begin
         failures++;
         $display("FAIL bp_drop got=%0b exp=0", drop_o);
      end
      out_ready_i = 1'b1;
      for (int i = 5; i <= 6; i++) send_honour(1'b1, longint'(i));
      idle(15);
      expect_got("bp", '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6});
   endtask

   task automatic test_drop();
      got_q.delete();
      shift_i     = 6'd0;
      out_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) send_honour(1'b1, longint'($urandom_range(0, 1000)));
      beat(1'b1, 1'b1, 999);
      checks++;
      if (drop_o !== 1'b1) begin
         failures++;
         $display("FAIL drop_set got=%0b exp=1", drop_o);
      end
      idle(5);
      checks++;
      if (drop_o !== 1'b1) begin
         failures++;
         $display("FAIL drop_sticky got=%0b exp=1", drop_o);
      end
      out_ready_i = 1'b1;
      idle(20);
      checks++;
      if (got_q.size() !== 4) begin
         failures++;
         $display("FAIL drop_result_count got=%0d exp=4", got_q.size());
      end
      clear_i = 1'b1;
      idle(1);
      clear_i = 1'b0;
      checks++;
      if (drop_o !== 1'b0) begin
         failures++;
         $display("FAIL drop_clear got=%0b exp=0", drop_o);
      end
   endtask

   task automatic test_reset_mid();
      got_q.delete();
      shift_i     = 6'd0;
      out_ready_i = 1'b0;
      beat(1'b1, 1'b1, 50);
      idle(8);
      beat(1'b1, 1'b0, 20);
      beat(1'b1, 1'b0, 30);
      launch_valid_i = 1'b0;
      launch_last_i  = 1'b0;
      #2;
      rst_ni = 1'b0;
      #1;
      checks++;
      if (out_valid_o !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%0b exp=0", out_valid_o); end
      checks++;
      if (out_data_o !== '0) begin failures++; $display("FAIL rstmid_out_data got=%08h exp=0", out_data_o); end
      checks++;
      if (drop_o !== 1'b0) begin failures++; $display("FAIL rstmid_drop got=%0b exp=0", drop_o); end
      reset_model();
      @(posedge clk_i);
      @(negedge clk_i);
      cyc++;
      rst_ni      = 1'b1;
      out_ready_i = 1'b1;
      beat(1'b1, 1'b1, 9);
      idle(12);
      expect_got("rstmid", '{32'd9});
   endtask

   task automatic test_clear_mid();
      got_q.delete();
      shift_i     = 6'd0;
      out_ready_i = 1'b0;
      beat(1'b1, 1'b1, 50);
      idle(8);
      beat(1'b1, 1'b0, 20);
      beat(1'b1, 1'b0, 30);
      clear_i = 1'b1;
      beat(1'b1, 1'b1, 77);
      clear_i = 1'b0;
      checks++;
      if (out_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL clrmid_out_valid got=%0b exp=0", out_valid_o);
      end
      out_ready_i = 1'b1;
      beat(1'b1, 1'b1, 9);
      idle(12);
      expect_got("clrmid", '{32'd9});
   endtask

   task automatic test_random();
      bit     v;
      bit     l;
      longint s;
      idle(TREE_LAT + 2);
      shift_i = 6'($urandom_range(0, 40));
      for (int i = 0; i < 800; i++) begin
         v = ($urandom_range(0, 99) < 60);
         l = ($urandom_range(0, 99) < 35);
         if (v && launch_ready_o !== 1'b1 && $urandom_range(0, 99) < 85) v = 1'b0;
         if ($urandom_range(0, 1) == 1) s = longint'($urandom_range(0, 2_000_000)) - 1_000_000;
         else s = longint'({$urandom, $urandom});
         out_ready_i = ($urandom_range(0, 99) < 50);
         clear_i     = ($urandom_range(0, 199) == 0);
         beat(v, l, s);
      end
      clear_i     = 1'b0;
      out_ready_i = 1'b1;
      idle(20);
      checks++;
      if (out_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL random_drain got=%0b exp=0", out_valid_o);
      end
   endtask

   initial begin
      rst_ni         = 1'b0;
      clear_i        = 1'b0;
      launch_valid_i = 1'b0;
      launch_last_i  = 1'b0;
      launch_sum     = '0;
      shift_i        = 6'd0;
      out_ready_i    = 1'b0;
      reset_model();
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;

      test_reset();
      test_single_pixel();
      test_multi_channel();
      test_saturation();
      test_backpressure();
      test_drop();
      test_reset_mid();
      test_clear_mid();
      test_random();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
